// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer and its forwarding lanes.
package store_buffer_pkg;

    localparam int BE_W          = 4;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [29:0]     waddr;
        logic [31:0]     data;
        logic [BE_W-1:0] be;
        logic [31:0]     pc;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_lane.sv
// One byte lane of store-to-load forwarding: picks the youngest hitting entry.
module sb_fwd_lane #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]      hit,      // index 0 = oldest, DEPTH-1 = youngest
    input  logic [DEPTH-1:0][7:0] data,
    input  logic [7:0]            mem_byte,
    output logic [7:0]            fwd_byte
);

    // Later (younger) hits overwrite earlier ones.
    always_comb begin
        fwd_byte = mem_byte;
        for (int j = 0; j < DEPTH; j++) begin
            if (hit[j]) fwd_byte = data[j];
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer in front of a single-ported data memory, with
// byte-granular store-to-load forwarding from resident entries.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_valid,
    input  logic [31:0]     st_addr,
    input  logic [31:0]     st_data,
    input  logic [BE_W-1:0] st_be,
    input  logic [31:0]     st_pc,
    output logic            st_ready,
    input  logic            ld_valid,
    input  logic [31:0]     ld_addr,
    input  logic [31:0]     dm_rdata,
    output logic [31:0]     ld_data,
    output logic            dm_we,
    output logic [31:0]     dm_addr,
    output logic [31:0]     dm_data,
    output logic [BE_W-1:0] dm_be,
    output logic [31:0]     dm_pc,
    output logic            full,
    output logic            empty
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);

    sb_entry_t         ent [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              push, drain;
    sb_entry_t         hd;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = (count < DEPTH_C);
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign push     = st_valid && st_ready;
    // Loads own the memory port; drains only steal idle cycles.
    assign drain    = (count != '0) && !ld_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (drain) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (push && !drain)      count <= count + 1'b1;
            else if (drain && !push) count <= count - 1'b1;
        end
    end

    // Payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) ent[tail] <= '{waddr: st_addr[31:2], data: st_data, be: st_be, pc: st_pc};
    end

    assign hd      = ent[head];
    assign dm_we   = drain;
    assign dm_addr = drain ? {hd.waddr, 2'b00} : '0;
    assign dm_data = drain ? hd.data : '0;
    assign dm_be   = drain ? hd.be   : '0;
    assign dm_pc   = drain ? hd.pc   : '0;

    // Rotate entries into age order (oldest first) so each lane can take the last hit.
    logic [BE_W-1:0][DEPTH-1:0]      lane_hit;
    logic [BE_W-1:0][DEPTH-1:0][7:0] lane_data;

    always_comb begin
        logic [PW-1:0] idx;
        idx       = head;
        lane_hit  = '0;
        lane_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = head + PW'(j);
            for (int k = 0; k < BE_W; k++) begin
                lane_hit[k][j]  = ld_valid && valid[idx] &&
                                  (ent[idx].waddr == ld_addr[31:2]) && ent[idx].be[k];
                lane_data[k][j] = ent[idx].data[8*k +: 8];
            end
        end
    end

    for (genvar k = 0; k < BE_W; k++) begin : g_lane
        sb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
            .hit      (lane_hit[k]),
            .data     (lane_data[k]),
            .mem_byte (dm_rdata[8*k +: 8]),
            .fwd_byte (ld_data[8*k +: 8])
        );
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports st_valid in 1, st_addr in 32, st_data in 32, st_be in 4, st_pc in 32, for a store from the MEM stage.
REQ-005 The block SHALL have port st_ready, output, 1, meaning the buffer can accept a store this cycle.
REQ-006 The block SHALL have ports ld_valid in 1 and ld_addr in 32, for a load issued by the MEM stage.
REQ-007 The block SHALL have port dm_rdata, input, 32, the combinational read word from the data memory at ld_addr.
REQ-008 The block SHALL have port ld_data, output, 32, the load word after store-to-load byte merging.
REQ-009 The block SHALL have ports dm_we out 1, dm_addr out 32, dm_data out 32, dm_be out 4, dm_pc out 32, driving the data-memory write port.
REQ-010 The block SHALL have ports full out 1 and empty out 1, giving occupancy status.

Function
REQ-011 The buffer SHALL be a FIFO of entries {word address st_addr[31:2], data, be, pc}; stores leave in program order.
REQ-012 st_ready SHALL equal (count < DEPTH), with no dependence on a same-cycle drain.
REQ-013 A push SHALL occur on a rising edge when st_valid and st_ready are both 1; st_valid with st_ready 0 SHALL be ignored, and the MEM stage stalls.
REQ-014 The data memory is single-ported, so a drain SHALL occur on a rising edge only when count > 0 and ld_valid is 0.
REQ-015 dm_we SHALL equal (count > 0 and !ld_valid); dm_addr SHALL equal {head word address, 2'b00}; dm_data, dm_be and dm_pc SHALL come from the head entry, all combinationally.
REQ-016 When dm_we is 0, dm_addr, dm_data, dm_be and dm_pc SHALL be 0.
REQ-017 A simultaneous push and drain SHALL leave count unchanged and advance both pointers.
REQ-018 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 For each byte lane k, ld_data[8k+7:8k] SHALL come from the youngest valid entry whose word address equals ld_addr[31:2] and whose be[k] is 1; otherwise it SHALL come from dm_rdata.
REQ-020 The store being pushed in the same cycle SHALL NOT take part in forwarding; only entries already resident SHALL.
REQ-021 When ld_valid is 0, ld_data SHALL equal dm_rdata.
REQ-022 A push with st_be == 0 SHALL be accepted and drained like any other entry.
REQ-023 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0).

Reset
REQ-024 While reset is 0, count, head and tail SHALL be 0, and all entry valid bits SHALL be cleared asynchronously.
REQ-025 After reset, st_ready SHALL be 1, empty SHALL be 1, full SHALL be 0 and dm_we SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all pending stores, with no write to the data memory.

Structure
REQ-027 A shared package SHALL hold the store-entry struct typedef, the byte-enable width constant (4) and DEPTH_DEFAULT.
REQ-028 Per-lane youngest-match selection SHALL be one sub-module, sb_fwd_lane, instantiated four times.
REQ-029 Entry storage SHALL be flops, not inferred RAM, so that all entries can be compared in parallel.

Verification
REQ-030 Reset, then push one store (0x0000_0010, 0xAABBCCDD, be 4'b1111, pc 0x3000) with ld_valid 0 -> on the next cycle dm_we is 1 with matching dm_* fields; after that edge, empty is 1.
REQ-031 Hold ld_valid 1 and push 4 stores -> full is 1 and st_ready is 0; a fifth st_valid is dropped; releasing ld_valid drains 4 writes in order, one per cycle.
REQ-032 Buffer holds 0x10/0x11111111/be 4'b1111, then 0x10/0x000000FF/be 4'b0001; load 0x10 with dm_rdata 0xDEADBEEF -> ld_data is 0x111111FF.
REQ-033 Buffer holds be 4'b1100 data 0xABCD0000 at 0x20; load 0x20 with dm_rdata 0x12345678 -> ld_data is 0xABCD5678; load 0x24 -> ld_data is 0x12345678.
REQ-034 With the buffer at count 3, push and drain in the same cycle for 2*DEPTH cycles -> count stays 3, pointers wrap, and the drain order matches the push order.
REQ-035 Pull reset low while the buffer holds 2 entries -> dm_we is 0 immediately and empty is 1; no stale write appears after reset is released.
